// File: rtl/rz_frame_sequencer_if.sv
// rz_frame_sequencer_if: host write/start bus plus encoder ready/enable handshake.
//   master: sequencer side (drives busy, frame_done, rz_data, rz_enable)
//   slave : host/encoder side (drives wr_en, wr_addr, wr_data, start, rz_ready)
interface rz_frame_sequencer_if #(
   parameter int DATA_WIDTH = 24,
   parameter int ADDR_WIDTH = 2
);
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  start;
   logic                  busy;
   logic                  frame_done;
   logic [DATA_WIDTH-1:0] rz_data;
   logic                  rz_enable;
   logic                  rz_ready;
   modport master (
      input  wr_en, wr_addr, wr_data, start, rz_ready,
      output busy, frame_done, rz_data, rz_enable
   );
   modport slave (
      output wr_en, wr_addr, wr_data, start, rz_ready,
      input  busy, frame_done, rz_data, rz_enable
   );
endinterface

// File: rtl/rz_frame_sequencer.sv
// rz_frame_sequencer: stores one frame of pixel words and streams it into the unipolar_rz encoder.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus.wr_*     : host pixel writes (out-of-range addresses ignored)
//   bus.start    : frame request, honoured only when idle
//   bus.busy     : high from start acceptance until frame_done
//   bus.frame_done: one-cycle pulse after the encoder's latch period ends
//   bus.rz_*     : encoder word/enable/ready handshake
module rz_frame_sequencer #(
   parameter int DATA_WIDTH  = 24,
   parameter int PIXEL_COUNT = 4,
   parameter int ADDR_WIDTH  = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1,
   parameter bit BIT_REVERSE = 1'b1
) (
   input logic                  clock,
   input logic                  reset,
   rz_frame_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
   localparam logic [ADDR_WIDTH:0] PIX_N = PIXEL_COUNT[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] ONE   = 1;
   logic [DATA_WIDTH-1:0] mem [PIXEL_COUNT];
   state_t                state, state_nx;
   logic [ADDR_WIDTH:0]   ptr, ptr_nx;
   logic                  guard, guard_nx;
   logic                  enable, enable_nx;
   logic                  busy, busy_nx;
   logic                  done, done_nx;
   logic [DATA_WIDTH-1:0] data, data_nx;
   logic                  take;
   function automatic logic [DATA_WIDTH-1:0] map(input logic [DATA_WIDTH-1:0] w);
      logic [DATA_WIDTH-1:0] r;
      for (int i = 0; i < DATA_WIDTH; i++)
         r[i] = BIT_REVERSE ? w[DATA_WIDTH-1-i] : w[i];
      return r;
   endfunction
   // Pixel store is deliberately not reset so a frame survives an aborting reset.
   always_ff @(posedge clock)
      if (bus.wr_en && ({1'b0, bus.wr_addr} < PIX_N))
         mem[bus.wr_addr] <= bus.wr_data;
   // The encoder may hold ready one cycle after we act on it, so ready is masked for that cycle.
   assign take = bus.rz_ready && !guard;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state  <= IDLE;
         ptr    <= '0;
         guard  <= 1'b0;
         enable <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         data   <= '0;
      end else begin
         state  <= state_nx;
         ptr    <= ptr_nx;
         guard  <= guard_nx;
         enable <= enable_nx;
         busy   <= busy_nx;
         done   <= done_nx;
         data   <= data_nx;
      end
   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      guard_nx  = 1'b0;
      enable_nx = 1'b0;
      busy_nx   = busy;
      done_nx   = 1'b0;
      data_nx   = data;
      case (state)
         IDLE:
            // The done cycle still belongs to the finishing frame, so start is refused there.
            if (bus.start && !done) begin
               state_nx = STREAM;
               ptr_nx   = '0;
               busy_nx  = 1'b1;
            end
         STREAM:
            if (take) begin
               guard_nx = 1'b1;
               if (ptr < PIX_N) begin
                  enable_nx = 1'b1;
                  data_nx   = map(mem[ptr[ADDR_WIDTH-1:0]]);
                  ptr_nx    = ptr + ONE;
               end else
                  // Withholding enable at ready sends the encoder into its latch period.
                  state_nx = DRAIN;
            end
         DRAIN:
            if (take) begin
               guard_nx = 1'b1;
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
               state_nx = IDLE;
            end
         default: state_nx = IDLE;
      endcase
   end
   assign bus.busy       = busy;
   assign bus.frame_done = done;
   assign bus.rz_data    = data;
   assign bus.rz_enable  = enable;
endmodule
